// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one command, drives the ALU, waits for the
// datapath to settle, then returns the result. Optional zero flag: ALU_SEQ_ZERO_FLAG_EN.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  ALUindex,
  output logic        ifslt,
  output logic        invertB,
  output logic        carryin,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic        rsp_zero
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  idx_q, idx_d;
  logic        slt_q, slt_d;
  logic        inv_q, inv_d;
  logic        cin_q, cin_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;

  logic [2:0]  dec_idx;
  logic        dec_slt;
  logic        dec_inv;

  always_comb begin
    dec_idx = 3'd0;
    dec_slt = 1'b0;
    dec_inv = 1'b0;
    case (req_cmd)
      3'd0: dec_idx = 3'd0;
      3'd1: begin
        dec_idx = 3'd0;
        dec_inv = 1'b1;
      end
      3'd2: dec_idx = 3'd2;
      3'd3: begin
        dec_idx = 3'd1;
        dec_slt = 1'b1;
        dec_inv = 1'b1;
      end
      3'd4: dec_idx = 3'd3;
      3'd5: dec_idx = 3'd4;
      3'd6: dec_idx = 3'd5;
      default: dec_idx = 3'd6;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    slt_d   = slt_q;
    inv_d   = inv_q;
    cin_d   = cin_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          idx_d   = dec_idx;
          slt_d   = dec_slt;
          inv_d   = dec_inv;
          cin_d   = dec_inv;
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          res_d   = alu_result;
          zero_d  = (alu_result == 32'd0);
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      idx_q   <= 3'd0;
      slt_q   <= 1'b0;
      inv_q   <= 1'b0;
      cin_q   <= 1'b0;
      res_q   <= 32'd0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      slt_q   <= slt_d;
      inv_q   <= inv_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = res_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign ALUindex   = idx_q;
  assign ifslt      = slt_q;
  assign invertB    = inv_q;
  assign carryin    = cin_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign rsp_zero = zero_q;
`else
  logic unused_zero;
  assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU behind each DUT.
// Build with ALU_SEQ_ZERO_FLAG_EN to exercise rsp_zero.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_valid_x;
  logic [2:0]  req_cmd;
  logic [31:0] req_a, req_b;
  logic        rsp_ready, rsp_ready_x;

  logic        req_ready, rsp_valid, ifslt, invertB, carryin;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [2:0]  ALUindex;

  logic        rr1, rv1, sl1, iv1, ci1;
  logic [31:0] a1, b1, ar1, rs1;
  logic [2:0]  ix1;
  logic        rr15, rv15, sl15, iv15, ci15;
  logic [31:0] a15, b15, ar15, rs15;
  logic [2:0]  ix15;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        rsp_zero, z1, z15;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(
    input logic [31:0] a, input logic [31:0] b,
    input logic [2:0] idx, input logic inv, input logic cin);
    logic [31:0] bb, s;
    logic ovf;
    bb  = inv ? ~b : b;
    s   = a + bb + {31'd0, cin};
    ovf = (a[31] == bb[31]) && (s[31] != a[31]);
    case (idx)
      3'd0: return s;
      3'd1: return {31'd0, s[31] ^ ovf};
      3'd2: return a ^ b;
      3'd3: return a & b;
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return a | b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, ALUindex, invertB, carryin);
  assign ar1  = alu_f(a1, b1, ix1, iv1, ci1);
  assign ar15 = alu_f(a15, b15, ix15, iv15, ci15);

  alu_op_sequencer #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .ALUindex(ALUindex),
    .ifslt(ifslt), .invertB(invertB), .carryin(carryin),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );

  alu_op_sequencer #(.SETTLE_CYCLES(1)) u_d1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_x), .req_ready(rr1),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .alu_a(a1), .alu_b(b1), .ALUindex(ix1),
    .ifslt(sl1), .invertB(iv1), .carryin(ci1),
    .alu_result(ar1),
    .rsp_valid(rv1), .rsp_ready(rsp_ready_x),
    .rsp_result(rs1)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .rsp_zero(z1)
`endif
  );

  alu_op_sequencer #(.SETTLE_CYCLES(15)) u_d15 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_x), .req_ready(rr15),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .alu_a(a15), .alu_b(b15), .ALUindex(ix15),
    .ifslt(sl15), .invertB(iv15), .carryin(ci15),
    .alu_result(ar15),
    .rsp_valid(rv15), .rsp_ready(rsp_ready_x),
    .rsp_result(rs15)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .rsp_zero(z15)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic rsp_hs;
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  // issue one op, check latency, registered decode and result
  task automatic run_op(input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r);
    int n;
    logic [2:0] eidx [8];
    logic e_inv;
    eidx = '{3'd0, 3'd0, 3'd2, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
    e_inv = (c == 3'd1) || (c == 3'd3);
    @(negedge clk);
    req_valid = 1'b1; req_cmd = c; req_a = a; req_b = b;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(n);
    chk($sformatf("lat_c%0d", c), n, 32'd3);
    chk($sformatf("idx_c%0d", c), {29'd0, ALUindex}, {29'd0, eidx[c]});
    chk($sformatf("ctl_c%0d", c), {29'd0, ifslt, invertB, carryin},
        {29'd0, (c == 3'd3), e_inv, e_inv});
    chk($sformatf("ops_c%0d", c), alu_a ^ alu_b, a ^ b);
    chk($sformatf("res_c%0d", c), rsp_result, exp_r);
    rsp_hs();
  endtask

  initial begin
    int n, l1, l15;
    logic seen;
    logic [31:0] A, B;
    logic [31:0] gold [8];
    A = 32'hF0F0F0F0;
    B = 32'h0FF00FF0;
    gold = '{32'h00E100E0, 32'hE100E100, 32'hFF00FF00, 32'h00000001,
             32'h00F000F0, 32'hFF0FFF0F, 32'h000F000F, 32'hFFF0FFF0};
    reset_n = 1'b0;
    req_valid = 1'b0; req_valid_x = 1'b0;
    req_cmd = 3'd0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; rsp_ready_x = 1'b0;
    #12;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_ops", alu_a | alu_b, 32'd0);
    chk("rst_ctl", {26'd0, ALUindex, ifslt, invertB, carryin}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    run_op(3'd1, 32'd5, 32'd7, 32'hFFFFFFFE);
    for (int c = 0; c < 8; c++) run_op(3'(c), A, B, gold[c]);
    run_op(3'd3, 32'd7, 32'd5, 32'd0);

    // backpressure: response held while a new request waits
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 3'd0; req_a = 32'd10; req_b = 32'd20;
    @(posedge clk); #1;
    req_cmd = 3'd7; req_a = 32'h00FF0000; req_b = 32'h000000FF;
    wait_rsp(n);
    chk("bp_lat", n, 32'd3);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_result !== 32'd30 || req_ready !== 1'b0 || rsp_valid !== 1'b1)
        seen = 1'b1;
    end
    chk("bp_stable", {31'd0, seen}, 32'd0);
    chk("bp_ops_held", alu_a, 32'd10);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_no_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_2nd_idx", {29'd0, ALUindex}, 32'd6);
    wait_rsp(n);
    chk("bp_2nd_lat", n, 32'd3);
    chk("bp_2nd_res", rsp_result, 32'h00FF00FF);
    rsp_hs();

    // reset during SETTLE abandons the op
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 3'd1; req_a = 32'd9; req_b = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("settle_ready", {31'd0, req_ready}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ops", alu_a | alu_b, 32'd0);
    chk("arst_ctl", {26'd0, ALUindex, ifslt, invertB, carryin}, 32'd0);
    chk("arst_rsp", {rsp_result[30:0], rsp_valid}, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("arst_no_rsp", {31'd0, seen}, 32'd0);
    run_op(3'd0, 32'd100, 32'd23, 32'd123);

    run_op(3'd2, 32'h12345678, 32'h12345678, 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("zero_set", {31'd0, rsp_zero}, 32'd1);
`endif
    run_op(3'd7, 32'd1, 32'd0, 32'd1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("zero_clr", {31'd0, rsp_zero}, 32'd0);
`endif

    // SETTLE_CYCLES = 1 and 15 latency
    @(negedge clk);
    req_valid_x = 1'b1; req_cmd = 3'd4; req_a = A; req_b = B;
    @(posedge clk); #1;
    req_valid_x = 1'b0;
    n = 1; l1 = 0; l15 = 0;
    while (n < 40 && (l1 == 0 || l15 == 0)) begin
      if (rv1 && l1 == 0) l1 = n;
      if (rv15 && l15 == 0) l15 = n;
      @(posedge clk); #1;
      n++;
    end
    chk("lat_s1", l1, 32'd2);
    chk("lat_s15", l15, 32'd16);
    chk("res_s1", rs1, 32'h00F000F0);
    chk("res_s15", rs15, 32'h00F000F0);
    @(negedge clk); rsp_ready_x = 1'b1;
    @(posedge clk); #1; rsp_ready_x = 1'b0;
    chk("s_idle", {30'd0, rr1, rr15}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the number of cycles the ALU datapath settles before capture; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all flops rise-edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req_valid in 1, req_ready out 1, req_cmd in 3, req_a in 32, req_b in 32, the command request channel.
REQ-005 The block SHALL have ports alu_a out 32, alu_b out 32, ALUindex out 3, ifslt out 1, invertB out 1, carryin out 1, all driving the ALU and its result multiplexer.
REQ-006 The block SHALL have port alu_result, input, 32, the multiplexer output.
REQ-007 The block SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_result out 32, the response channel.

Function
REQ-008 Command decode SHALL be: ADD 0 -> ALUindex 0, invertB 0, carryin 0; SUB 1 -> index 0, invertB 1, carryin 1; XOR 2 -> index 2; SLT 3 -> index 1, ifslt 1, invertB 1, carryin 1; AND 4 -> index 3; NAND 5 -> index 4; NOR 6 -> index 5; OR 7 -> index 6.
REQ-009 ifslt SHALL be 1 only for SLT; invertB and carryin SHALL be 0 for all commands other than SUB and SLT.
REQ-010 The FSM SHALL have states IDLE, SETTLE, RESP.
REQ-011 In IDLE, req_ready SHALL be 1; req_valid&req_ready SHALL register req_cmd, req_a, req_b, load settle counter with SETTLE_CYCLES-1 and go to SETTLE.
REQ-012 In SETTLE, req_ready SHALL be 0, ALU control and operand outputs SHALL hold the registered decode, counter decrements each cycle.
REQ-013 When the counter is 0 in SETTLE, alu_result SHALL be captured into rsp_result and state SHALL go to RESP with rsp_valid 1 the next cycle.
REQ-014 Acceptance-to-rsp_valid latency SHALL be exactly SETTLE_CYCLES+1 cycles.
REQ-015 In RESP, rsp_valid and rsp_result SHALL stay stable until rsp_valid&rsp_ready; then state SHALL go to IDLE.
REQ-016 req_ready SHALL be 0 in RESP; a request is not accepted in the cycle the response completes (one-deep, no overlap).
REQ-017 ALU control and operand outputs SHALL hold their last value in IDLE and RESP.
REQ-018 req_* inputs SHALL be ignored whenever req_ready is 0.

Reset
REQ-019 On reset_n low, state SHALL go to IDLE immediately, counter 0, rsp_valid 0, rsp_result 0, alu_a 0, alu_b 0, ALUindex 0, ifslt 0, invertB 0, carryin 0.
REQ-020 Reset asserted mid-SETTLE or mid-RESP SHALL abandon the operation with no response issued.
REQ-021 req_ready SHALL be 1 in the first cycle after reset_n deasserts.

Configuration
REQ-022 With macro ALU_SEQ_ZERO_FLAG_EN defined, the block SHALL add output rsp_zero, 1 bit, captured with rsp_result, equal to 1 when the captured alu_result is all zeros, reset 0, held stable with rsp_result.
REQ-023 Without ALU_SEQ_ZERO_FLAG_EN, port rsp_zero and its logic SHALL not exist.

Verification
REQ-024 Reset then req SUB a=5 b=7, SETTLE_CYCLES=2, alu_result model -> ALUindex 0, invertB 1, carryin 1; rsp_valid on cycle 3 after accept, rsp_result 0xFFFFFFFE.
REQ-025 All 8 commands with a=0xF0F0F0F0 b=0x0FF00FF0 -> decode per REQ-008, ifslt only for cmd 3, results match golden model.
REQ-026 rsp_ready held 0 for 5 cycles in RESP, req_valid 1 with new cmd -> rsp_result stable, req_ready 0, second request accepted only after the response handshake.
REQ-027 reset_n pulsed low in SETTLE cycle 1 -> all outputs at reset values asynchronously, no rsp_valid, next request completes normally.
REQ-028 With ALU_SEQ_ZERO_FLAG_EN, XOR a=b=0x12345678 -> rsp_result 0, rsp_zero 1; OR a=1 b=0 -> rsp_zero 0.
REQ-029 SETTLE_CYCLES=1 and 15 -> latency 2 and 16 cycles respectively.
